// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset PC,
// fetch state encoding, queue entry layout and small address helpers.
package fetch_pkg;

    localparam int unsigned INST_W  = 32;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned ENTRY_W = INST_W + PC_W;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0040_0000;

    // RUN fetches normally; HALT is entered on a misaligned redirect target
    // and is only left through reset.
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    // One instruction queue entry: fetched word plus the byte PC it came from.
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

    // A fetch target is legal only when it is word aligned.
    function automatic logic is_misaligned(input logic [PC_W-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Instruction queue: DEPTH entries of {inst, pc}. Supports push and pop on
// the same edge, and a flush that empties the queue (flush wins over both).
module inst_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  fetch_entry_t             push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output fetch_entry_t             head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          pop_ok_s;
    logic          push_ok_s;

    // Guard the queue against popping when empty or pushing when truly full.
    always_comb begin
        pop_ok_s  = 1'b0;
        push_ok_s = 1'b0;
        if (flush_i) begin
            pop_ok_s  = 1'b0;
            push_ok_s = 1'b0;
        end else begin
            pop_ok_s  = pop_i && (count_q != '0);
            push_ok_s = push_i && ((count_q < DEPTH_C) || pop_ok_s);
        end
    end

    // Entry storage: only the tail slot is written, and only on an accepted push.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers and occupancy; pointer wrap relies on DEPTH being a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + CW'(1'b1);
                2'b01:   count_q <= count_q - CW'(1'b1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: issues sequential word reads to instruction memory,
// queues returned words with their PCs, and delivers them in order to the
// downstream consumer. Redirects flush all fetched-but-unconsumed work; a
// misaligned redirect target halts fetch with a sticky exception.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_en,
    output logic [29:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        except
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    fetch_state_e  state_q;
    logic [31:0]   pc_q;
    logic [31:0]   pc_d;
    logic          inflight_q;
    logic [31:0]   inflight_pc_q;
    logic          except_q;

    logic [CW-1:0] fifo_count_s;
    logic [CW:0]   occupancy_s;
    logic          redirect_act_s;
    logic          misaligned_s;
    logic          issue_s;
    logic          head_valid_s;
    logic          push_s;
    logic          pop_s;
    fetch_entry_t  push_entry_s;
    fetch_entry_t  head_entry_s;

    // Issue, push/pop and next-PC decisions; a redirect overrides everything else.
    always_comb begin
        redirect_act_s = 1'b0;
        misaligned_s   = 1'b0;
        issue_s        = 1'b0;
        head_valid_s   = 1'b0;
        push_s         = 1'b0;
        pop_s          = 1'b0;
        pc_d           = pc_q;

        // Queued entries plus the outstanding read bound how far ahead we fetch.
        occupancy_s = {1'b0, fifo_count_s} + {{CW{1'b0}}, inflight_q};

        if (state_q == ST_RUN) begin
            redirect_act_s = redirect;
        end else begin
            redirect_act_s = 1'b0;
        end
        misaligned_s = redirect_act_s && is_misaligned(redirect_pc);

        if (!reset && (state_q == ST_RUN) && !redirect && (occupancy_s < DEPTH_C)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end

        head_valid_s = (fifo_count_s != '0) && (state_q == ST_RUN);

        if (redirect_act_s) begin
            push_s = 1'b0;
            pop_s  = 1'b0;
            pc_d   = redirect_pc;
        end else begin
            push_s = inflight_q;
            pop_s  = head_valid_s && inst_ready;
            if (issue_s) begin
                pc_d = pc_q + 32'd4;
            end else begin
                pc_d = pc_q;
            end
        end

        push_entry_s.inst = imem_data;
        push_entry_s.pc   = inflight_pc_q;
    end

    // Fetch state machine with PC, outstanding-read tracking and sticky exception.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0000_0000;
            except_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= issue_s;
            if (issue_s) begin
                inflight_pc_q <= pc_q;
            end
            case (state_q)
                ST_RUN: begin
                    if (misaligned_s) begin
                        state_q  <= ST_HALT;
                        except_q <= 1'b1;
                    end
                end
                ST_HALT: begin
                    state_q  <= ST_HALT;
                    except_q <= 1'b1;
                end
                default: begin
                    state_q  <= ST_HALT;
                    except_q <= 1'b1;
                end
            endcase
        end
    end

    inst_fifo #(
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (push_s),
        .push_data_i (push_entry_s),
        .pop_i       (pop_s),
        .flush_i     (redirect_act_s),
        .head_o      (head_entry_s),
        .count_o     (fifo_count_s)
    );

    assign imem_en    = issue_s;
    assign imem_addr  = pc_q[31:2];
    assign inst_valid = head_valid_s;
    assign inst       = head_entry_s.inst;
    assign inst_pc    = head_entry_s.pc;
    assign except     = except_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit. A queue-based reference model
// tracks every issued fetch (PC and the cycle its data becomes deliverable)
// and predicts imem_en/imem_addr, inst_valid/inst/inst_pc and except each cycle.
module tb_inst_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clock;
    logic        reset;
    logic        imem_en;
    logic [29:0] imem_addr;
    logic [31:0] imem_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        except;

    inst_fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .except      (except)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory content is tagged by address so every word identifies its PC.
    function automatic logic [31:0] tag(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0000;
    endfunction

    // Instruction memory: one-cycle read latency.
    logic        rsp_v;
    logic [29:0] rsp_addr;
    always @(posedge clock) begin
        rsp_v    <= imem_en;
        rsp_addr <= imem_addr;
    end
    assign imem_data = rsp_v ? tag({rsp_addr, 2'b00}) : 32'hDEAD_BEEF;

    // Reference model state.
    typedef struct {
        logic [31:0] pc;
        int          avail;
    } ent_t;

    ent_t        pend[$];
    logic [31:0] fetch_pc;
    bit          halted;
    int          cyc;
    int          checks;
    int          errors;
    int          issues;
    int          deliv;

    task automatic chk(input string name, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", name, observed, expected, cyc);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        fetch_pc = RESET_PC;
        halted   = 1'b0;
        cyc      = 0;
    endtask

    // Assert reset part-way through a cycle, check outputs clear at once,
    // hold it across one rising edge, then release.
    task automatic do_reset();
        @(negedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_imem_en", {63'd0, imem_en}, 64'd0);
        chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rst_except", {63'd0, except}, 64'd0);
        @(posedge clock);
        #1;
        chk("rst_hold_imem_en", {63'd0, imem_en}, 64'd0);
        reset       = 1'b0;
        redirect    = 1'b0;
        inst_ready  = 1'b0;
        redirect_pc = 32'h0000_0000;
        model_reset();
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance model.
    task automatic do_cycle(input logic rdy, input logic rd, input logic [31:0] rpc);
        bit   e_en;
        bit   e_valid;
        ent_t e;
        @(negedge clock);
        inst_ready  = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
        e_en    = !halted && !rd && (pend.size() < DEPTH);
        e_valid = !halted && (pend.size() > 0) && (pend[0].avail <= cyc);
        chk("imem_en", {63'd0, imem_en}, {63'd0, e_en});
        if (e_en) chk("imem_addr", {34'd0, imem_addr}, {34'd0, fetch_pc[31:2]});
        chk("inst_valid", {63'd0, inst_valid}, {63'd0, e_valid});
        if (e_valid) begin
            chk("inst_pc", {32'd0, inst_pc}, {32'd0, pend[0].pc});
            chk("inst", {32'd0, inst}, {32'd0, tag(pend[0].pc)});
        end
        chk("except", {63'd0, except}, {63'd0, halted});
        if (imem_en) issues++;
        if (!halted && rd) begin
            pend.delete();
            fetch_pc = rpc;
            if (rpc[1:0] != 2'b00) halted = 1'b1;
        end else begin
            if (e_valid && rdy) begin
                pend.delete(0);
                deliv++;
            end
            if (e_en) begin
                e.pc    = fetch_pc;
                e.avail = cyc + 2;
                pend.push_back(e);
                fetch_pc = fetch_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    initial begin
        logic [31:0] r;
        checks      = 0;
        errors      = 0;
        issues      = 0;
        deliv       = 0;
        reset       = 1'b1;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0000_0000;
        model_reset();
        repeat (2) @(posedge clock);

        // Reset release, then straight-line fetch with the consumer always ready.
        do_reset();
        for (int i = 0; i < 8; i++) do_cycle(1'b1, 1'b0, 32'h0);

        // Consumer stalls: exactly DEPTH reads issue, head holds, then drains in order.
        do_reset();
        issues = 0;
        for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'b0, 32'h0);
        chk("stall_issue_count", 64'(issues), 64'd4);
        for (int i = 0; i < 10; i++) do_cycle(1'b1, 1'b0, 32'h0);

        // Redirect with three queued entries and one read outstanding.
        do_reset();
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b0, 32'h0);
        do_cycle(1'b1, 1'b1, 32'h0040_0100);
        for (int i = 0; i < 8; i++) do_cycle(1'b1, 1'b0, 32'h0);

        // Redirect near the top of the address space: PC wraps silently.
        do_cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 6; i++) do_cycle(1'b1, 1'b0, 32'h0);

        // Randomised ready and aligned redirects.
        deliv = 0;
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            if (r[7:4] == 4'h0) begin
                do_cycle(r[0], 1'b1, $urandom & 32'hFFFF_FFFC);
            end else begin
                do_cycle(r[0] | r[1], 1'b0, 32'h0);
            end
        end
        chk("random_progress", {63'd0, (deliv > 50)}, 64'd1);

        // Reset mid-stream clears everything and restarts at the reset PC.
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, 32'h0);
        do_reset();
        for (int i = 0; i < 6; i++) do_cycle(1'b1, 1'b0, 32'h0);

        // Misaligned redirect halts with a sticky exception; later redirects ignored.
        do_cycle(1'b1, 1'b1, 32'h0040_0102);
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, 32'h0);
        do_cycle(1'b1, 1'b1, 32'h0040_0200);
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, 32'h0);
        chk("halt_except_sticky", {63'd0, except}, 64'd1);
        do_reset();
        chk("post_reset_except", {63'd0, except}, 64'd0);
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 SHALL have parameter: DEPTH, 4, instruction queue entries (power of 2, >=2).
REQ-002 SHALL have parameter: RESET_PC, 32'h00400000, first fetch address after reset.
REQ-003 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: imem_en  output  1  instruction-memory read request this cycle.
REQ-006 SHALL have port: imem_addr  output  30  word address (pc[31:2]) of the request.
REQ-007 SHALL have port: imem_data  input  32  read data; valid exactly one cycle after imem_en.
REQ-008 SHALL have port: inst_valid  output  1  queue head holds a valid instruction.
REQ-009 SHALL have port: inst  output  32  instruction at queue head.
REQ-010 SHALL have port: inst_pc  output  32  byte PC of inst.
REQ-011 SHALL have port: inst_ready  input  1  downstream arith machine consumes head this cycle.
REQ-012 SHALL have port: redirect  input  1  branch/jump: restart fetch at redirect_pc.
REQ-013 SHALL have port: redirect_pc  input  32  new fetch byte address.
REQ-014 SHALL have port: except  output  1  sticky fetch fault (misaligned redirect target).

Function
REQ-015 SHALL have states RUN and HALT only; RUN after reset; RUN->HALT on redirect with redirect_pc[1:0]!=0; HALT is left only by reset.
REQ-016 SHALL assert imem_en combinationally iff state==RUN, redirect==0, and (count + inflight) < DEPTH.
REQ-017 SHALL drive imem_addr = pc[31:2]; pc <= pc + 4 on each issue; 32-bit wrap (0xFFFFFFFC -> 0x00000000) is silent.
REQ-018 SHALL register one in-flight flag plus its PC; response imem_data is pushed at queue tail on the following edge unless discarded by redirect.
REQ-019 SHALL present queue head on inst/inst_pc with inst_valid=(count!=0); head pops on edge where inst_valid && inst_ready.
REQ-020 SHALL permit push and pop on the same edge (count unchanged), including when count==DEPTH-1 or DEPTH; overflow is impossible by REQ-016.
REQ-021 SHALL keep inst/inst_pc stable while inst_valid && !inst_ready.
REQ-022 SHALL, on aligned redirect: empty queue (count=0), drop in-flight response, pc <= redirect_pc, no issue that cycle; first new fetch issues the next cycle.
REQ-023 SHALL, on misaligned redirect: flush as REQ-022, enter HALT, assert except from the next cycle; in HALT imem_en=0, inst_valid=0, redirect ignored.
REQ-024 SHALL give latency: issue in cycle t -> inst_valid with that instruction in cycle t+2; aligned redirect in cycle t -> inst_valid at t+3.
REQ-025 SHALL sustain one instruction per cycle when inst_ready is held high.
REQ-026 SHALL give redirect priority over a simultaneous pop and push in the same cycle (both discarded).

Reset
REQ-027 SHALL on reset: pc=RESET_PC, state=RUN, count=0, inflight=0, except=0, inst_valid=0, imem_en=0 while reset high.
REQ-028 SHALL on reset mid-operation discard queue contents and in-flight response immediately (asynchronous).

Structure
REQ-029 SHALL place RESET_PC default, state encodings and instruction width constant in shared package fetch_pkg.
REQ-030 SHALL implement storage as sub-module inst_fifo (DEPTH x 64 bits: inst+pc, push/pop/flush, count output).

Verification
REQ-031 SHALL test reset release, inst_ready=1, memory returns addr-tagged data -> imem_addr 0x00100000 in cycle 0, inst_valid cycle 2 with inst_pc 0x00400000, then 0x00400004, 0x00400008 on consecutive cycles.
REQ-032 SHALL test inst_ready=0 for 10 cycles -> exactly 4 imem_en issues, imem_en=0 thereafter, head stays inst_pc 0x00400000; ready=1 resumes 1/cycle with no loss or duplicate.
REQ-033 SHALL test redirect to 0x00400100 while queue holds 3 entries and one in flight -> inst_valid=0 next cycle, next delivered inst_pc 0x00400100 at t+3, stale data never delivered.
REQ-034 SHALL test redirect to 0x00400102 -> except=1 next cycle and sticky, imem_en=0, inst_valid=0; later aligned redirect ignored; reset clears except.
REQ-035 SHALL test redirect to 0xFFFFFFF8 -> inst_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, except=0.
REQ-036 SHALL test reset asserted mid-stream for 1 cycle -> outputs cleared asynchronously, fetch restarts at 0x00400000.
